// File: rtl/cpu_obi_addr_demux.sv
// cpu_obi_addr_demux: per-core OBI address demultiplexer.
// Decodes each request against an address rule table and routes it to one
// of NumSlaves private slaves (system bus, CPU private register block).
// Responses stay in order because a request to a new target waits until
// every outstanding response has drained.
// Optional feature macro: CPU_OBI_DEMUX_ERR_SLAVE_EN enables an internal
// error responder for unmapped addresses (target index NumSlaves).

package cei_mochila_pkg;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;

  localparam int unsigned CPU_XBAR_NUM_RULES = 3;

  // Rule 0: private register block; rules 1 and 2: system bus windows
  localparam addr_map_rule_t [CPU_XBAR_NUM_RULES-1:0] CPU_XBAR_ADDR_RULES = {
    addr_map_rule_t'{idx: 32'd0, start_addr: 32'hF001_0000, end_addr: 32'hF100_0000},
    addr_map_rule_t'{idx: 32'd0, start_addr: 32'h4000_0000, end_addr: 32'h8000_0000},
    addr_map_rule_t'{idx: 32'd1, start_addr: 32'hF000_0000, end_addr: 32'hF001_0000}
  };

endpackage

module cpu_obi_addr_demux #(
  parameter int unsigned NumSlaves = 2,
  parameter int unsigned NumRules = 3,
  parameter cei_mochila_pkg::addr_map_rule_t [NumRules-1:0] AddrRules =
    cei_mochila_pkg::CPU_XBAR_ADDR_RULES,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      m_req_i,
  output logic                      m_gnt_o,
  input  logic [31:0]               m_addr_i,
  input  logic                      m_we_i,
  input  logic [3:0]                m_be_i,
  input  logic [31:0]               m_wdata_i,
  output logic                      m_rvalid_o,
  output logic [31:0]               m_rdata_o,
  output logic                      m_err_o,
  output logic [NumSlaves-1:0]      s_req_o,
  input  logic [NumSlaves-1:0]      s_gnt_i,
  output logic [31:0]               s_addr_o,
  output logic                      s_we_o,
  output logic [3:0]                s_be_o,
  output logic [31:0]               s_wdata_o,
  input  logic [NumSlaves-1:0]      s_rvalid_i,
  input  logic [NumSlaves*32-1:0]   s_rdata_i,
  output logic                      busy_o
);

`ifdef CPU_OBI_DEMUX_ERR_SLAVE_EN
  localparam int unsigned NumTgt = NumSlaves + 1;
`else
  localparam int unsigned NumTgt = NumSlaves;
`endif
  localparam int unsigned SelW = (NumTgt > 1) ? $clog2(NumTgt) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic            dec_hit;
  logic [SelW-1:0] dec_idx;
  logic [SelW-1:0] dec_tgt;
  logic            allowed;
  logic            hs;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [SelW-1:0] tgt_q;
  logic            busy_q;
  logic            rsp_valid;
  logic [31:0]     rsp_data;
`ifdef CPU_OBI_DEMUX_ERR_SLAVE_EN
  localparam logic [31:0] ErrData = 32'hBADA_CCE5;
  logic            err_rvalid_q;
  logic            rsp_err;
`endif

  // Request fields are broadcast; only s_req_o selects the slave
  assign s_addr_o  = m_addr_i;
  assign s_we_o    = m_we_i;
  assign s_be_o    = m_be_i;
  assign s_wdata_o = m_wdata_i;
  assign busy_o    = busy_q;

  // Address decode: first (lowest index) matching rule wins, end exclusive
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = 0; i < NumRules; i++) begin
      if (!dec_hit && (m_addr_i >= AddrRules[i].start_addr) &&
          (m_addr_i < AddrRules[i].end_addr)) begin
        dec_hit = 1'b1;
        dec_idx = SelW'(AddrRules[i].idx);
      end
    end
`ifdef CPU_OBI_DEMUX_ERR_SLAVE_EN
    dec_tgt = dec_hit ? dec_idx : SelW'(NumSlaves);
`else
    dec_tgt = dec_hit ? dec_idx : '0;
`endif
  end

  // A request proceeds only with room left and no pending responses elsewhere
  assign allowed = (cnt_q < CntW'(MaxOutstanding)) &&
                   ((cnt_q == '0) || (dec_tgt == tgt_q));

  // Request routing and grant return
  always_comb begin
    s_req_o = '0;
    m_gnt_o = 1'b0;
    if (allowed) begin
      for (int k = 0; k < NumSlaves; k++) begin
        if (dec_tgt == SelW'(k)) begin
          s_req_o[k] = m_req_i;
          m_gnt_o    = s_gnt_i[k];
        end
      end
`ifdef CPU_OBI_DEMUX_ERR_SLAVE_EN
      if (dec_tgt == SelW'(NumSlaves)) begin
        m_gnt_o = m_req_i;
      end
`endif
    end
  end

  assign hs = m_req_i & m_gnt_o;

  // Response selection by current target; nothing is forwarded when idle
  always_comb begin
    rsp_valid = 1'b0;
    rsp_data  = '0;
`ifdef CPU_OBI_DEMUX_ERR_SLAVE_EN
    rsp_err   = 1'b0;
`endif
    if (cnt_q != '0) begin
      for (int k = 0; k < NumSlaves; k++) begin
        if (tgt_q == SelW'(k)) begin
          rsp_valid = s_rvalid_i[k];
          rsp_data  = s_rdata_i[k*32 +: 32];
        end
      end
`ifdef CPU_OBI_DEMUX_ERR_SLAVE_EN
      if (tgt_q == SelW'(NumSlaves)) begin
        rsp_valid = err_rvalid_q;
        rsp_data  = ErrData;
        rsp_err   = 1'b1;
      end
`endif
    end
    m_rvalid_o = rsp_valid;
    m_rdata_o  = rsp_valid ? rsp_data : '0;
`ifdef CPU_OBI_DEMUX_ERR_SLAVE_EN
    m_err_o    = rsp_valid & rsp_err;
`else
    m_err_o    = 1'b0;
`endif
  end

  // Outstanding count: +1 per handshake, -1 per response, both cancel
  always_comb begin
    cnt_d = cnt_q;
    case ({hs, m_rvalid_o})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      tgt_q        <= '0;
      busy_q       <= 1'b0;
`ifdef CPU_OBI_DEMUX_ERR_SLAVE_EN
      err_rvalid_q <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
      if (hs) begin
        tgt_q <= dec_tgt;
      end
`ifdef CPU_OBI_DEMUX_ERR_SLAVE_EN
      err_rvalid_q <= hs && (dec_tgt == SelW'(NumSlaves));
`endif
    end
  end

`ifndef SYNTHESIS
  // Flag slave responses that do not belong to an outstanding transaction
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      for (int k = 0; k < NumSlaves; k++) begin
        if (s_rvalid_i[k]) begin
          assert ((cnt_q != '0) && (tgt_q == SelW'(k)))
            else $warning("cpu_obi_addr_demux: stray rvalid from slave %0d ignored", k);
        end
      end
    end
  end
`endif

endmodule
